fifo_write_arbiter: RTL and testbench
=====================================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 The block SHALL have parameter BURST, default 4, giving the maximum accepted writes per grant before rotation.
REQ-002 The block SHALL have parameter PTR_W, default 5, giving the FIFO pointer width (32 entries).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 The block SHALL have port req0  input  1  producer 0 requests to write.
REQ-006 The block SHALL have port req1  input  1  producer 1 requests to write.
REQ-007 The block SHALL have port full  input  1  FIFO controller full flag.
REQ-008 The block SHALL have port wr_en  input  1  FIFO controller acceptance strobe (write taken this cycle).
REQ-009 The block SHALL have port wr  output  1  write command to the FIFO controller.
REQ-010 The block SHALL have port gnt0  output  1  producer 0 owns the write port.
REQ-011 The block SHALL have port gnt1  output  1  producer 1 owns the write port.
REQ-012 The block SHALL have port sel  output  1  data-mux select; 0 = producer 0, 1 = producer 1; valid while gnt0 or gnt1.
REQ-013 The block SHALL have port beats  output  $clog2(BURST+1)  accepted writes in the current grant.

Function
REQ-014 The FSM SHALL have states IDLE, OWN0 and OWN1; gnt0 = (state==OWN0), gnt1 = (state==OWN1), and sel = (state==OWN1), all registered.
REQ-015 wr SHALL be (gnt0&req0 | gnt1&req1) & ~full, combinational from registered state; wr SHALL never assert in IDLE.
REQ-016 A beat SHALL count only when wr & wr_en are both high; beats increments by 1 per counted beat.
REQ-017 IDLE -> OWNx SHALL occur one cycle after reqx is seen; if both requesters are high, the grant goes to the producer not recorded in last_served.
REQ-018 last_served SHALL update to x whenever the FSM enters OWNx.
REQ-019 In OWNx, if reqx drops, the next state SHALL be OWNy when reqy is high, else IDLE; beats SHALL clear to 0.
REQ-020 In OWNx, when the counted beat makes beats reach BURST and reqy is high, the next state SHALL be OWNy and beats SHALL clear.
REQ-021 In OWNx, when beats reaches BURST and reqy is low, the FSM SHALL stay in OWNx and beats SHALL clear (a new burst for the same owner).
REQ-022 While full is high, the grant SHALL be held, wr SHALL be 0, and beats SHALL not change; the rotation rules of REQ-019 still apply if reqx drops.
REQ-023 If wr is high but wr_en is low (controller rejection), no beat SHALL be counted and the FSM SHALL stay in its state.
REQ-024 A grant SHALL switch directly OWN0 <-> OWN1 with no IDLE bubble; at most one of gnt0/gnt1 SHALL be high in any cycle.

Reset
REQ-025 While rst is low: state = IDLE, gnt0 = gnt1 = 0, sel = 0, wr = 0, beats = 0, last_served = 1 (producer 0 wins the first tie).
REQ-026 Reset asserted mid-burst SHALL drop the grant and wr in the same cycle (asynchronous), with no counted beat.

Structure
REQ-027 Package fifo_arb_pkg SHALL hold the state enum (IDLE, OWN0, OWN1), the BURST and PTR_W defaults, and the beats-width constant.
REQ-028 The beat counter (count, clear, terminal-count flag) SHALL be one sub-module named burst_counter; FSM and output logic SHALL stay in fifo_write_arbiter.

Verification
REQ-029 Reset with req0 = req1 = 1, release -> one cycle later gnt0 = 1, sel = 0; after 4 accepted beats -> gnt1 = 1 on the next cycle.
REQ-030 Only req1 held for 10 cycles with wr_en = wr -> gnt1 stays high; beats sequence 1,2,3,4(clear) repeats; gnt0 never asserts.
REQ-031 OWN0 with beats = 2, full raised for 3 cycles -> wr = 0, beats stays 2, gnt0 held; full drops -> beats resumes at 3.
REQ-032 OWN0, req0 drops while req1 = 1 -> next cycle gnt1 = 1, beats = 0, no IDLE cycle; both req low -> IDLE, wr = 0.
REQ-033 Pair with the FIFO controller, 32-deep: alternate producers fill it -> exactly 32 wr_en pulses, 16 per producer; wr = 0 once full = 1.
REQ-034 Assert rst mid-burst (beats = 3) -> gnt0, gnt1, wr = 0 immediately; after release, a tie is granted to producer 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared definitions for the two-producer FIFO write arbiter:
//   grant FSM state type, parameter defaults and the beat-counter width.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam int unsigned BURST_DEFAULT = 4;
    localparam int unsigned PTR_W_DEFAULT = 5;

    // Width needed to hold a beat count of 0..burst.
    function automatic int unsigned beats_width(input int unsigned burst);
        return $clog2(burst + 1);
    endfunction

    localparam int unsigned BEATS_W_DEFAULT = beats_width(BURST_DEFAULT);

endpackage

// File: rtl/fifo_write_arbiter_burst_counter.sv
// burst_counter
//   Counts accepted writes within one grant.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   count : an accepted write happens this cycle
//   clear : return the count to zero next cycle (wins over count)
//   beats : accepted writes so far in the current burst
//   tc    : this accepted write completes the burst
module burst_counter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned BURST = BURST_DEFAULT,
    parameter int unsigned W     = beats_width(BURST)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         count,
    input  logic         clear,
    output logic [W-1:0] beats,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(BURST - 1);

    // The burst-completing write is flagged combinationally so the owner can
    // rotate on the very next edge; the counter therefore never shows BURST.
    assign tc = count & (beats == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beats <= '0;
        end else if (clear) begin
            beats <= '0;
        end else if (count) begin
            beats <= beats + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter giving one of two producers the write port of a FIFO
//   controller, rotating after BURST accepted writes or when the owner drops
//   its request.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   req0  : producer 0 wants to write
//   req1  : producer 1 wants to write
//   full  : FIFO full flag
//   wr_en : FIFO accepted the write this cycle
//   wr    : write command to the FIFO
//   gnt0  : producer 0 owns the port
//   gnt1  : producer 1 owns the port
//   sel   : data-mux select (0 = producer 0, 1 = producer 1)
//   beats : accepted writes in the current grant
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned BURST = BURST_DEFAULT,
    parameter int unsigned PTR_W = PTR_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req0,
    input  logic                         req1,
    input  logic                         full,
    input  logic                         wr_en,
    output logic                         wr,
    output logic                         gnt0,
    output logic                         gnt1,
    output logic                         sel,
    output logic [$clog2(BURST+1)-1:0]   beats
);

    localparam int unsigned BEATS_W = beats_width(BURST);

    // A burst longer than the FIFO can never complete.
    if (BURST < 1 || BURST > (1 << PTR_W)) begin : g_burst_check
        $error("fifo_write_arbiter: BURST must be 1..2**PTR_W");
    end

    state_t state;
    state_t next_state;
    logic   last_served;
    logic   count;
    logic   clear;
    logic   tc;

    assign gnt0  = (state == OWN0);
    assign gnt1  = (state == OWN1);
    assign sel   = (state == OWN1);
    assign wr    = ((gnt0 & req0) | (gnt1 & req1)) & ~full;
    assign count = wr & wr_en;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (req0 && req1) begin
                    next_state = last_served ? OWN0 : OWN1;
                end else if (req0) begin
                    next_state = OWN0;
                end else if (req1) begin
                    next_state = OWN1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    next_state = req1 ? OWN1 : IDLE;
                end else if (tc && req1) begin
                    next_state = OWN1;
                end
            end
            OWN1: begin
                if (!req1) begin
                    next_state = req0 ? OWN0 : IDLE;
                end else if (tc && req0) begin
                    next_state = OWN0;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Any change of owner, or a completed burst kept by the same owner,
    // starts a fresh count.
    assign clear = (next_state != state) | tc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_served <= 1'b1;
        end else begin
            state <= next_state;
            if (next_state == OWN0) begin
                last_served <= 1'b0;
            end else if (next_state == OWN1) begin
                last_served <= 1'b1;
            end
        end
    end

    burst_counter #(
        .BURST (BURST),
        .W     (BEATS_W)
    ) u_burst_counter (
        .clk   (clk),
        .rst   (rst),
        .count (count),
        .clear (clear),
        .beats (beats),
        .tc    (tc)
    );

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter
//   Directed scenarios plus a randomized run, each cycle compared against a
//   behavioural model of the grant/burst rules.
module tb_fifo_write_arbiter;

    localparam int BURST = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0;
    logic       req1;
    logic       full;
    logic       wr_en;
    logic       wr;
    logic       gnt0;
    logic       gnt1;
    logic       sel;
    logic [2:0] beats;

    fifo_write_arbiter #(
        .BURST (BURST),
        .PTR_W (5)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .req1  (req1),
        .full  (full),
        .wr_en (wr_en),
        .wr    (wr),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .sel   (sel),
        .beats (beats)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: owner 0 = nobody, 1 = producer 0, 2 = producer 1.
    int m_own;
    int m_last;
    int m_bts;

    int obs_w0;
    int obs_w1;
    int g0_seen;
    int fifo_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_wr(input bit r0, input bit r1, input bit f);
        return ((m_own == 1 && r0) || (m_own == 2 && r1)) && !f;
    endfunction

    task automatic m_step(input bit r0, input bit r1, input bit f, input bit we);
        int  nxt;
        bit  beat;
        bit  rx;
        bit  ry;
        int  other;
        nxt  = m_own;
        beat = m_wr(r0, r1, f) && we;
        if (m_own == 0) begin
            if (r0 && r1)  nxt = (m_last == 1) ? 1 : 2;
            else if (r0)   nxt = 1;
            else if (r1)   nxt = 2;
            m_bts = 0;
        end else begin
            rx    = (m_own == 1) ? r0 : r1;
            ry    = (m_own == 1) ? r1 : r0;
            other = (m_own == 1) ? 2 : 1;
            if (!rx) begin
                nxt   = ry ? other : 0;
                m_bts = 0;
            end else if (beat) begin
                if (m_bts + 1 == BURST) begin
                    m_bts = 0;
                    if (ry) nxt = other;
                end else begin
                    m_bts++;
                end
            end
        end
        if (nxt != 0) m_last = nxt - 1;
        m_own = nxt;
    endtask

    // we_mode: 0 / 1 drive wr_en constant, 2 = controller accepts every write.
    task automatic cycle(input bit r0, input bit r1, input bit f, input int we_mode);
        req0  = r0;
        req1  = r1;
        full  = f;
        wr_en = (we_mode == 2) ? m_wr(r0, r1, f) : (we_mode == 1);
        @(negedge clk);
        check("gnt0",  gnt0,  m_own == 1);
        check("gnt1",  gnt1,  m_own == 2);
        check("sel",   sel,   m_own == 2);
        check("beats", beats, m_bts);
        check("wr",    wr,    m_wr(r0, r1, f));
        if (wr && wr_en) begin
            if (gnt0) obs_w0++;
            if (gnt1) obs_w1++;
        end
        if (gnt0) g0_seen++;
        m_step(r0, r1, f, wr_en);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        full  = 1'b0;
        wr_en = 1'b0;
        m_own = 0;
        m_last = 1;
        m_bts = 0;
        @(posedge clk);
        #1;
        check("rst_gnt0",  gnt0,  0);
        check("rst_gnt1",  gnt1,  0);
        check("rst_sel",   sel,   0);
        check("rst_wr",    wr,    0);
        check("rst_beats", beats, 0);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; full = 1'b0; wr_en = 1'b0;

        // Tie after reset goes to producer 0, rotates after four beats.
        do_reset();
        cycle(1, 1, 0, 2);
        check("tie_gnt0", gnt0, 1);
        check("tie_sel",  sel,  0);
        repeat (4) cycle(1, 1, 0, 2);
        check("rot_gnt1", gnt1, 1);
        check("rot_beats", beats, 0);
        repeat (6) cycle(1, 1, 0, 2);

        // Single requester keeps re-bursting.
        do_reset();
        g0_seen = 0;
        repeat (10) cycle(0, 1, 0, 2);
        check("solo_gnt1", gnt1, 1);
        check("solo_no_gnt0", g0_seen, 0);

        // Full stalls the count and holds the grant.
        do_reset();
        repeat (3) cycle(1, 0, 0, 2);
        check("pre_full_beats", beats, 2);
        repeat (3) cycle(1, 0, 1, 2);
        check("full_beats", beats, 2);
        check("full_gnt0",  gnt0,  1);
        cycle(1, 0, 0, 2);
        check("resume_beats", beats, 3);

        // Rejected write is not counted.
        cycle(1, 0, 0, 0);
        check("reject_beats", beats, 3);

        // Owner drops: direct hand-over, then idle.
        cycle(0, 1, 0, 2);
        check("handover_gnt1",  gnt1,  1);
        check("handover_beats", beats, 0);
        cycle(0, 0, 0, 2);
        check("idle_gnt1", gnt1, 0);
        check("idle_wr",   wr,   0);

        // Fill a 32-deep FIFO from both producers.
        do_reset();
        fifo_cnt = 0;
        obs_w0 = 0;
        obs_w1 = 0;
        repeat (60) begin
            cycle(1, 1, fifo_cnt == 32, 2);
            if (wr_en) fifo_cnt++;
        end
        check("fill_total", obs_w0 + obs_w1, 32);
        check("fill_p0",    obs_w0, 16);
        check("fill_p1",    obs_w1, 16);

        // Asynchronous reset mid-burst.
        do_reset();
        repeat (4) cycle(1, 0, 0, 2);
        check("mid_beats", beats, 3);
        req0  = 1'b1;
        full  = 1'b0;
        wr_en = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("async_gnt0",  gnt0,  0);
        check("async_gnt1",  gnt1,  0);
        check("async_wr",    wr,    0);
        check("async_beats", beats, 0);
        m_own = 0; m_last = 1; m_bts = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1, 1, 0, 2);
        check("post_rst_tie", gnt0, 1);

        // Randomized traffic.
        do_reset();
        repeat (400) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
